// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - icache/dcache arbiter driving one RAM port with error retry/abort
// Optional: ICACHE_STARVE_GUARD_EN forces an icache grant after STARVE_LIMIT dcache grants.
module cache_mem_responder #(
    parameter int STARVE_LIMIT  = 4,
    parameter int ERR_RETRY_MAX = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        mem_err
);

    typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, ABORT} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam int ERR_W = $clog2(ERR_RETRY_MAX + 1);
    localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_RETRY_MAX - 1);

    state_t           state, next_state;
    logic [ERR_W-1:0] err_cnt;
    logic             gnt_i;
    logic             dreq;
    logic             force_i;

    assign dreq = dREN | dWEN;

`ifdef ICACHE_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT) + 1;
    logic [STARVE_W-1:0] starve_cnt;

    assign force_i = iREN && (starve_cnt == STARVE_W'(STARVE_LIMIT));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (!iREN || next_state == I_ACC)
                starve_cnt <= '0;
            else if (next_state == D_ACC)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign force_i = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            err_cnt <= '0;
            gnt_i   <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                D_ACC, I_ACC: begin
                    gnt_i <= (state == I_ACC);
                    if (ramstate == RAM_ERROR && next_state != IDLE)
                        err_cnt <= err_cnt + 1'b1;
                    else if (next_state == IDLE)
                        err_cnt <= '0;
                end
                default: err_cnt <= '0;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (force_i)
                    next_state = I_ACC;
                else if (dreq)
                    next_state = D_ACC;
                else if (iREN)
                    next_state = I_ACC;
            end
            D_ACC: begin
                if (!dreq || ramstate == RAM_ACCESS)
                    next_state = IDLE;
                else if (ramstate == RAM_ERROR && err_cnt == ERR_LAST)
                    next_state = ABORT;
            end
            I_ACC: begin
                if (!iREN || ramstate == RAM_ACCESS)
                    next_state = IDLE;
                else if (ramstate == RAM_ERROR && err_cnt == ERR_LAST)
                    next_state = ABORT;
            end
            default: next_state = IDLE;
        endcase
    end

    // A dropped request drives nothing to the RAM in that cycle.
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        mem_err  = 1'b0;
        case (state)
            D_ACC: begin
                if (dreq) begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    if (ramstate == RAM_ACCESS) begin
                        dwait = 1'b0;
                        dload = dWEN ? 32'd0 : ramload;
                    end
                end
            end
            I_ACC: begin
                if (iREN) begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    if (ramstate == RAM_ACCESS) begin
                        iwait = 1'b0;
                        iload = ramload;
                    end
                end
            end
            ABORT: begin
                mem_err = 1'b1;
                if (gnt_i)
                    iwait = 1'b0;
                else
                    dwait = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// tb/tb_cache_mem_responder.sv - scoreboard bench for cache_mem_responder
module tb_cache_mem_responder;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, mem_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    typedef struct packed {
        logic        side_i;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    cache_mem_responder #(.STARVE_LIMIT(4), .ERR_RETRY_MAX(3)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push(input logic side_i, input logic [31:0] data, input logic err);
        exp_t e;
        e.side_i = side_i;
        e.data   = data;
        e.err    = err;
        exp_q.push_back(e);
    endtask

    // Monitor: every completion (wait low or mem_err) must match the next queued expectation.
    always @(negedge CLK) begin
        if (nRST && (!iwait || !dwait || mem_err)) begin
            logic [66:0] act, req;
            exp_t e;
            act = {iwait, dwait, iload, dload, mem_err};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_completion: got %h expected none", act);
            end else begin
                e = exp_q.pop_front();
                req = e.side_i ? {1'b0, 1'b1, e.data, 32'd0, e.err}
                               : {1'b1, 1'b0, 32'd0, e.data, e.err};
                if (act !== req) begin
                    errors++;
                    $display("FAIL completion: got %h expected %h", act, req);
                end
            end
        end
    end

    task automatic chk_reset_vals(input string name);
        chk({name, "_waits"}, {30'd0, iwait, dwait}, 32'd3);
        chk({name, "_strobes"}, {29'd0, ramREN, ramWEN, mem_err}, 32'd0);
        chk({name, "_loads"}, iload | dload, 32'd0);
        chk({name, "_ramaddr"}, ramaddr, 32'd0);
        chk({name, "_ramstore"}, ramstore, 32'd0);
    endtask

    initial begin
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
        repeat (2) step();
        chk_reset_vals("reset");
        nRST = 1'b1;
        step();

        // Read with two BUSY cycles before ACCESS
        dREN = 1; daddr = 32'h40; ramstate = BUSY;
        step();
        chk("rd_ramREN", {31'd0, ramREN}, 32'd1);
        chk("rd_ramaddr", ramaddr, 32'h40);
        step();
        chk("rd_hold_addr", ramaddr, 32'h40);
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        push(1'b0, 32'hDEADBEEF, 1'b0);
        step();
        dREN = 0; ramstate = FREE;
        step();

        // Simultaneous iREN/dWEN: dcache first, then icache after an idle cycle
        iREN = 1; iaddr = 32'h100; dWEN = 1; daddr = 32'h80; dstore = 32'h1234;
        step();
        chk("wr_ramWEN", {30'd0, ramWEN, ramREN}, 32'd2);
        chk("wr_ramstore", ramstore, 32'h1234);
        chk("wr_iwait", {31'd0, iwait}, 32'd1);
        ramstate = ACCESS;
        push(1'b0, 32'd0, 1'b0);
        step();
        dWEN = 0; ramstate = FREE;
        chk("gap_idle", {29'd0, iwait, ramREN, ramWEN}, 32'd4);
        step();
        chk("i_ramaddr", ramaddr, 32'h100);
        chk("i_strobes", {30'd0, ramREN, ramWEN}, 32'd2);
        ramstate = ACCESS; ramload = 32'hCAFE0001;
        push(1'b1, 32'hCAFE0001, 1'b0);
        step();
        iREN = 0; ramstate = FREE;
        step();

        // Three ERROR responses abandon the read
        dREN = 1; daddr = 32'h44; ramstate = ERROR;
        step();
        chk("err_retry_strobe", {31'd0, ramREN}, 32'd1);
        step();
        step();
        chk("err_still_strobe", {31'd0, ramREN}, 32'd1);
        push(1'b0, 32'd0, 1'b1);
        step();
        dREN = 0; ramstate = FREE;
        step();
        chk("err_back_idle", {31'd0, ramREN}, 32'd0);
        step();

        // icache drops its request while RAM is BUSY
        iREN = 1; iaddr = 32'h200; ramstate = BUSY;
        step();
        chk("drop_ramREN", {31'd0, ramREN}, 32'd1);
        step();
        iREN = 0;
        #1;
        chk("drop_strobe_off", {30'd0, ramREN, iwait}, 32'd1);
        step();
        ramstate = FREE;
        step();

        // Asynchronous reset during a write
        dWEN = 1; daddr = 32'h300; dstore = 32'h55; ramstate = BUSY;
        step();
        chk("rst_pre_ramWEN", {31'd0, ramWEN}, 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        dWEN = 0;
        step();
        nRST = 1'b1;
        dREN = 1; daddr = 32'h48; ramstate = ACCESS; ramload = 32'h0BADF00D;
        step();
        chk("post_rst_addr", ramaddr, 32'h48);
        push(1'b0, 32'h0BADF00D, 1'b0);
        step();
        dREN = 0; ramstate = FREE;
        step();

        // Both requesters held high, RAM always ready
        ramstate = ACCESS; ramload = 32'h11; dREN = 1; daddr = 32'h60; iREN = 1; iaddr = 32'h70;
`ifdef ICACHE_STARVE_GUARD_EN
        for (int i = 0; i < 6; i++) push(i == 4, 32'h11, 1'b0);
`else
        for (int i = 0; i < 6; i++) push(1'b0, 32'h11, 1'b0);
`endif
        repeat (12) step();
        dREN = 0; iREN = 0; ramstate = FREE;
        repeat (3) step();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
